// File: rtl/mc_datapath.sv
// Multi-cycle datapath: one instruction at a time through DECODE/EXEC/(MEM)/WB,
// with the data memory reached over a req/ack port so slow memories stall the sequence.
module mc_datapath #(
   parameter int WIDTH    = 32,
   parameter int NREG     = 32,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inst_valid,
   output logic             inst_ready,
   input  logic [31:0]      inst,
   input  logic             regwrite,
   input  logic             regdst,
   input  logic             extop,
   input  logic             alusrc,
   input  logic             memwrite,
   input  logic             mem2reg,
   input  logic             shiftctrl,
   input  logic [3:0]       aluctrl,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             zero,
   output logic             msb,
   output logic [WIDTH-1:0] regout,
   output logic [WIDTH-1:0] write,
   output logic             done
);
   localparam int AW = $clog2(NREG);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
   state_e state_q, state_d;

   logic [31:0]      inst_q;
   logic             regwrite_q, regdst_q, extop_q, alusrc_q, memwrite_q, mem2reg_q, shiftctrl_q;
   logic [3:0]       aluctrl_q;
   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] a_q, b_q, imm_q, regout_q, mdr_q, write_q;
   logic             zero_q, msb_q;

   logic [AW-1:0]     rs_idx, rt_idx, rd_idx, waddr;
   logic [WIDTH+15:0] imm_wide;
   logic [WIDTH-1:0]  op2, alu_res, wb_data;
   logic [4:0]        shamt;
   logic              shift_ok, reg_we;
   logic              unused_bits;

   assign rs_idx   = inst_q[21 +: AW];
   assign rt_idx   = inst_q[16 +: AW];
   assign rd_idx   = inst_q[11 +: AW];
   assign waddr    = regdst_q ? rd_idx : rt_idx;
   assign imm_wide = {{WIDTH{extop_q & inst_q[15]}}, inst_q[15:0]};
   assign op2      = shiftctrl_q ? {{(WIDTH-5){1'b0}}, inst_q[10:6]} : (alusrc_q ? imm_q : b_q);
   assign shamt    = op2[4:0];
   assign shift_ok = (int'(shamt) < WIDTH);
   assign unused_bits = ^{inst_q, imm_wide};

   // A store with mem2reg also set still writes back the ALU result.
   assign wb_data = (mem2reg_q && !memwrite_q) ? mdr_q : regout_q;
   assign reg_we  = (state_q == S_WB) && regwrite_q && !((ZERO_REG != 0) && (waddr == '0));

   always_comb begin
      alu_res = '0;
      case (aluctrl_q)
         4'b0000: alu_res = a_q & op2;
         4'b0001: alu_res = a_q | op2;
         4'b0010: alu_res = a_q + op2;
         4'b0110: alu_res = a_q - op2;
         4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(op2))};
         4'b0011: alu_res = shift_ok ? (a_q << shamt) : '0;
         4'b0100: alu_res = shift_ok ? (a_q >> shamt) : '0;
         4'b1100: alu_res = ~(a_q | op2);
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      inst_ready = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      done       = 1'b0;
      case (state_q)
         S_IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid) state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = (memwrite_q || mem2reg_q) ? S_MEM : S_WB;
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = memwrite_q;
            if (mem_ack) state_d = S_WB;
         end
         S_WB: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q      <= '0;
         regwrite_q  <= 1'b0;
         regdst_q    <= 1'b0;
         extop_q     <= 1'b0;
         alusrc_q    <= 1'b0;
         memwrite_q  <= 1'b0;
         mem2reg_q   <= 1'b0;
         shiftctrl_q <= 1'b0;
         aluctrl_q   <= '0;
         a_q         <= '0;
         b_q         <= '0;
         imm_q       <= '0;
         regout_q    <= '0;
         zero_q      <= 1'b0;
         msb_q       <= 1'b0;
         mdr_q       <= '0;
         write_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (inst_valid) begin
               inst_q      <= inst;
               regwrite_q  <= regwrite;
               regdst_q    <= regdst;
               extop_q     <= extop;
               alusrc_q    <= alusrc;
               memwrite_q  <= memwrite;
               mem2reg_q   <= mem2reg;
               shiftctrl_q <= shiftctrl;
               aluctrl_q   <= aluctrl;
            end
            // Shifts operate on rt, so A takes rt instead of rs.
            S_DECODE: begin
               a_q   <= shiftctrl_q ? regs_q[rt_idx] : regs_q[rs_idx];
               b_q   <= regs_q[rt_idx];
               imm_q <= imm_wide[WIDTH-1:0];
            end
            S_EXEC: begin
               regout_q <= alu_res;
               zero_q   <= (alu_res == '0);
               msb_q    <= alu_res[WIDTH-1];
            end
            S_MEM:   if (mem_ack) mdr_q <= mem_rdata;
            S_WB:    if (regwrite_q) write_q <= wb_data;
            default: ;
         endcase
      end
   end

   // Register file cleared by reset, so it is built from flops rather than RAM.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                              regs_q[gi] <= '0;
         else if (reg_we && (waddr == AW'(gi)))   regs_q[gi] <= wb_data;
      end
   end

   assign mem_addr  = regout_q;
   assign mem_wdata = b_q;
   assign zero      = zero_q;
   assign msb       = msb_q;
   assign regout    = regout_q;
   assign write     = write_q;
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench: a 32-bit/32-register and a 16-bit/8-register datapath run the same
// instruction stream in lockstep; each is checked against hand-computed values.
module tb_mc_datapath;
   logic clk = 1'b0;
   logic rst_n;
   logic inst_valid;
   logic [31:0] inst;
   logic regwrite, regdst, extop, alusrc, memwrite, mem2reg, shiftctrl;
   logic [3:0] aluctrl;
   logic [31:0] mem_rdata;
   logic mem_ack;

   logic inst_ready1, mem_req1, mem_we1, zero1, msb1, done1;
   logic [31:0] mem_addr1, mem_wdata1, regout1, write1;
   logic inst_ready2, mem_req2, mem_we2, zero2, msb2, done2;
   logic [15:0] mem_addr2, mem_wdata2, regout2, write2;

   int checks = 0;
   int errors = 0;
   int last_req;
   logic [31:0] last_addr, last_wdata, last_addr2;
   logic last_we;

   localparam logic [10:0] C_ADDI  = 11'b1011000_0010;
   localparam logic [10:0] C_ADDIU = 11'b1001000_0010;
   localparam logic [10:0] C_SUB   = 11'b1100000_0110;
   localparam logic [10:0] C_SLT   = 11'b1100000_0111;
   localparam logic [10:0] C_SLL   = 11'b1100001_0011;
   localparam logic [10:0] C_SRL   = 11'b1100001_0100;
   localparam logic [10:0] C_NOR   = 11'b1100000_1100;
   localparam logic [10:0] C_OR    = 11'b1100000_0001;
   localparam logic [10:0] C_RD    = 11'b0000000_0001;
   localparam logic [10:0] C_SW    = 11'b0011100_0010;
   localparam logic [10:0] C_LW    = 11'b1011010_0010;

   always #5 clk = ~clk;

   mc_datapath #(.WIDTH(32), .NREG(32), .ZERO_REG(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready1), .inst(inst),
      .regwrite(regwrite), .regdst(regdst), .extop(extop), .alusrc(alusrc), .memwrite(memwrite),
      .mem2reg(mem2reg), .shiftctrl(shiftctrl), .aluctrl(aluctrl),
      .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .zero(zero1), .msb(msb1),
      .regout(regout1), .write(write1), .done(done1));

   mc_datapath #(.WIDTH(16), .NREG(8), .ZERO_REG(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready2), .inst(inst),
      .regwrite(regwrite), .regdst(regdst), .extop(extop), .alusrc(alusrc), .memwrite(memwrite),
      .mem2reg(mem2reg), .shiftctrl(shiftctrl), .aluctrl(aluctrl),
      .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(mem_rdata[15:0]), .mem_ack(mem_ack), .zero(zero2), .msb(msb2),
      .regout(regout2), .write(write2), .done(done2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   function automatic logic [31:0] ity(input int rs, input int rt, input logic [15:0] imm);
      return {6'd0, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] rty(input int rs, input int rt, input int rd, input int sh);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'd0};
   endfunction

   // Issue one instruction, serve memory with an ack in MEM cycle ack_after, and check
   // latency counted with the accept cycle as cycle 1.
   task automatic run(input logic [31:0] i, input logic [10:0] c, input int ack_after,
                      input int exp_lat, input string tag);
      int cyc;
      int memcyc;
      bit seen;
      @(negedge clk);
      inst = i;
      {regwrite, regdst, extop, alusrc, memwrite, mem2reg, shiftctrl, aluctrl} = c;
      inst_valid = 1'b1;
      @(posedge clk);
      #1 inst_valid = 1'b0;
      cyc = 1; memcyc = 0; seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done1) seen = 1'b1;
         else if (mem_req1) begin
            memcyc++;
            if (memcyc == ack_after) begin
               last_addr  = mem_addr1;
               last_wdata = mem_wdata1;
               last_we    = mem_we1;
               last_addr2 = 32'(mem_addr2);
               mem_ack    = 1'b1;
            end
         end
      end
      mem_ack  = 1'b0;
      last_req = memcyc;
      check({tag, ".lat"}, cyc, exp_lat);
      check({tag, ".done2"}, 32'(done2), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int r, input logic [31:0] e1, input logic [31:0] e2, input string tag);
      run(rty(r, 0, 0, 0), C_RD, 0, 4, tag);
      check({tag, ".d1"}, regout1, e1);
      check({tag, ".d2"}, 32'(regout2), e2);
   endtask

   initial begin
      int k;
      rst_n = 1'b0; inst_valid = 1'b0; inst = '0; mem_ack = 1'b0; mem_rdata = '0;
      {regwrite, regdst, extop, alusrc, memwrite, mem2reg, shiftctrl, aluctrl} = '0;
      repeat (2) @(negedge clk);
      check("rst.ready", 32'(inst_ready1), 32'd1);
      check("rst.regout", regout1, 32'd0);
      check("rst.write", write1, 32'd0);
      check("rst.done", 32'(done1), 32'd0);
      check("rst.req", 32'(mem_req1), 32'd0);
      rst_n = 1'b1;

      run(ity(1, 2, 16'hFFFB), C_ADDI, 0, 4, "addi");
      check("addi.write1", write1, 32'hFFFFFFFB);
      check("addi.msb1", 32'(msb1), 32'd1);
      check("addi.zero1", 32'(zero1), 32'd0);
      check("addi.write2", 32'(write2), 32'h0000FFFB);
      check("addi.msb2", 32'(msb2), 32'd1);
      rd(2, 32'hFFFFFFFB, 32'h0000FFFB, "rdR2");

      run(ity(0, 3, 16'd7), C_ADDI, 0, 4, "r3");
      run(ity(0, 4, 16'd7), C_ADDI, 0, 4, "r4");
      run(rty(3, 4, 5, 0), C_SUB, 0, 4, "sub");
      check("sub.zero1", 32'(zero1), 32'd1);
      check("sub.regout1", regout1, 32'd0);
      check("sub.zero2", 32'(zero2), 32'd1);
      run(ity(0, 4, 16'hFFFF), C_ADDI, 0, 4, "r4m1");
      run(rty(4, 3, 6, 0), C_SLT, 0, 4, "slt");
      check("slt.regout1", regout1, 32'd1);
      check("slt.regout2", 32'(regout2), 32'd1);
      rd(6, 32'd1, 32'd1, "rdR6");

      run(ity(0, 2, 16'd1), C_ADDI, 0, 4, "r2one");
      run(rty(0, 2, 8, 31), C_SLL, 0, 4, "sll31");
      check("sll31.d1", regout1, 32'h80000000);
      check("sll31.d2", 32'(regout2), 32'd0);
      check("sll31.msb1", 32'(msb1), 32'd1);
      run(rty(0, 2, 9, 0), C_SLL, 0, 4, "sll0");
      check("sll0.d1", regout1, 32'd1);
      check("sll0.d2", 32'(regout2), 32'd1);
      run(rty(0, 8, 10, 4), C_SRL, 0, 4, "srl");
      check("srl.d1", regout1, 32'h08000000);
      check("srl.d2", 32'(regout2), 32'd0);
      run(rty(0, 0, 11, 0), C_NOR, 0, 4, "nor");
      check("nor.d1", regout1, 32'hFFFFFFFF);
      check("nor.d2", 32'(regout2), 32'h0000FFFF);

      run(ity(0, 1, 16'h0010), C_ADDI, 0, 4, "r1");
      run(ity(1, 2, 16'd4), C_SW, 3, 7, "sw");
      check("sw.reqcyc", last_req, 32'd3);
      check("sw.addr1", last_addr, 32'h14);
      check("sw.addr2", last_addr2, 32'h14);
      check("sw.wdata", last_wdata, 32'd1);
      check("sw.we", 32'(last_we), 32'd1);
      mem_rdata = 32'h0000CAFE;
      run(ity(1, 7, 16'd4), C_LW, 1, 5, "lw");
      mem_rdata = '0;
      check("lw.we", 32'(last_we), 32'd0);
      check("lw.write1", write1, 32'h0000CAFE);
      check("lw.write2", 32'(write2), 32'h0000CAFE);
      rd(7, 32'h0000CAFE, 32'h0000CAFE, "rdR7");

      run(ity(0, 0, 16'd5), C_ADDI, 0, 4, "wr0");
      check("wr0.write", write1, 32'd5);
      rd(0, 32'd0, 32'd0, "rdR0");

      run(ity(0, 1, 16'h7FFF), C_ADDIU, 0, 4, "r1max");
      run(ity(1, 2, 16'd1), C_ADDI, 0, 4, "wrap");
      check("wrap.write1", write1, 32'h00008000);
      check("wrap.msb1", 32'(msb1), 32'd0);
      check("wrap.write2", 32'(write2), 32'h00008000);
      check("wrap.msb2", 32'(msb2), 32'd1);
      run(rty(2, 0, 27, 0), C_OR, 0, 4, "rd27");
      rd(3, 32'd7, 32'h00008000, "rdR3");

      @(negedge clk);
      inst = ity(1, 2, 16'd4);
      {regwrite, regdst, extop, alusrc, memwrite, mem2reg, shiftctrl, aluctrl} = C_SW;
      inst_valid = 1'b1;
      @(posedge clk);
      #1 inst_valid = 1'b0;
      k = 0;
      while (!mem_req1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("rstmem.reqbefore", 32'(mem_req1), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstmem.req1", 32'(mem_req1), 32'd0);
      check("rstmem.req2", 32'(mem_req2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rstmem.ready", 32'(inst_ready1), 32'd1);
      check("rstmem.regout", regout1, 32'd0);
      rd(3, 32'd0, 32'd0, "postrst.R3");
      rd(7, 32'd0, 32'd0, "postrst.R7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
